link_frame_sequencer: RTL

//  Run-time controller for the digital-transmission test chain (bit-source LFSR -> Manchester coder -> noise/FIR).

---
 rtl/link_frame_sequencer_pkg.sv | 31 +++
 rtl/link_frame_sequencer_if.sv | 50 +++++
 rtl/link_frame_sequencer_bit_rate_gen.sv | 60 ++++++
 rtl/link_frame_sequencer.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/link_frame_sequencer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : link_frame_sequencer_pkg                                     |
// | Description : Shared types and default constants for the link frame        |
// |               sequencer (state encoding, framing defaults, helpers).       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package link_frame_sequencer_pkg;

  // Sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_SYNC = 3'd2,
    ST_PAY  = 3'd3,
    ST_GAP  = 3'd4
  } seq_state_e;

  localparam int         PRE_BITS_DEF  = 8;
  localparam int         SYNC_W_DEF    = 8;
  localparam logic [7:0] SYNC_WORD_DEF = 8'hD5;
  localparam int         GAP_BITS_DEF  = 4;
  localparam int         DIV_MIN_DEF   = 4;

  // States in which a bit is presented to the Manchester coder.
  function automatic logic has_data(input seq_state_e s);
    return (s == ST_PRE) || (s == ST_SYNC) || (s == ST_PAY);
  endfunction

endpackage
`default_nettype wire

// File: rtl/link_frame_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : link_frame_sequencer_if                                      |
// | Description : Control/config inputs and strobe/data outputs of the link    |
// |               frame sequencer.                                             |
// |   start, stop          : frame request / abort request                     |
// |   cfg_div/len/loop/noise : frame configuration                             |
// |   lfsr_bit             : payload bit from the bit-source LFSR              |
// |   en0, en1             : bit-boundary / mid-bit strobes                    |
// |   lfsr_clken           : LFSR advance enable                               |
// |   tx_bit, tx_valid     : bit and qualifier to the Manchester coder         |
// |   noise_en, busy       : noise gate, sequencer active                      |
// |   frame_done, frame_cnt: completion pulse, completed-frame counter         |
// |   master = stimulus side, slave = sequencer side                           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface link_frame_sequencer_if #(
  parameter int DIV_W = 14,
  parameter int LEN_W = 10
);
  logic             start;
  logic             stop;
  logic [DIV_W-1:0] cfg_div;
  logic [LEN_W-1:0] cfg_len;
  logic             cfg_loop;
  logic             cfg_noise;
  logic             lfsr_bit;
  logic             en0;
  logic             en1;
  logic             lfsr_clken;
  logic             tx_bit;
  logic             tx_valid;
  logic             noise_en;
  logic             busy;
  logic             frame_done;
  logic [15:0]      frame_cnt;

  modport master (
    output start, stop, cfg_div, cfg_len, cfg_loop, cfg_noise, lfsr_bit,
    input  en0, en1, lfsr_clken, tx_bit, tx_valid, noise_en, busy,
           frame_done, frame_cnt
  );

  modport slave (
    input  start, stop, cfg_div, cfg_len, cfg_loop, cfg_noise, lfsr_bit,
    output en0, en1, lfsr_clken, tx_bit, tx_valid, noise_en, busy,
           frame_done, frame_cnt
  );
endinterface
`default_nettype wire

// File: rtl/link_frame_sequencer_bit_rate_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bit_rate_gen                                                 |
// | Description : Bit-period divider. Latches a clamped divisor on load and    |
// |               produces the bit-boundary (en0) and mid-bit (en1) strobes.   |
// |   clk, rst_n : clock, asynchronous active-low reset                        |
// |   run        : count while high, hold count at 0 while low                 |
// |   load       : latch max(cfg_div, DIV_MIN) and restart the count           |
// |   cfg_div    : requested clk cycles per bit                                |
// |   en0, en1   : 1-cycle strobes at cnt == div-1 and cnt == div/2-1          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module bit_rate_gen #(
  parameter int DIV_W   = 14,
  parameter int DIV_MIN = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             load,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             en0,
  output logic             en1
);

  localparam logic [DIV_W-1:0] DIV_MIN_V = DIV_W'(DIV_MIN);
  localparam logic [DIV_W-1:0] ONE_V     = DIV_W'(1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;

  assign en0 = run && (cnt_q == (div_q - ONE_V));
  assign en1 = run && (cnt_q == ((div_q >> 1) - ONE_V));

  always_comb begin
    div_d = div_q;
    cnt_d = cnt_q;
    if (load) begin
      div_d = (cfg_div < DIV_MIN_V) ? DIV_MIN_V : cfg_div;
    end
    // A load always begins a fresh bit period, so the count restarts with it.
    if (load || !run || en0) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + ONE_V;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= DIV_MIN_V;
      cnt_q <= '0;
    end else begin
      div_q <= div_d;
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/link_frame_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : link_frame_sequencer                                         |
// | Description : Run-time controller for the transmission test chain.         |
// |               Sequences PREAMBLE -> SYNC -> PAYLOAD -> GAP frames, single  |
// |               shot or looped, and gates the LFSR advance and noise.        |
// |   clk, rst_n : clock, asynchronous active-low reset                        |
// |   bus        : link_frame_sequencer_if.slave (config in, strobes/data out) |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module link_frame_sequencer
  import link_frame_sequencer_pkg::*;
#(
  parameter int                DIV_W     = 14,
  parameter int                LEN_W     = 10,
  parameter int                PRE_BITS  = PRE_BITS_DEF,
  parameter int                SYNC_W    = SYNC_W_DEF,
  parameter logic [SYNC_W-1:0] SYNC_WORD = SYNC_W'(SYNC_WORD_DEF),
  parameter int                GAP_BITS  = GAP_BITS_DEF,
  parameter int                DIV_MIN   = DIV_MIN_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  link_frame_sequencer_if.slave bus
);

  localparam logic [LEN_W-1:0] ONE_L      = LEN_W'(1);
  localparam logic [LEN_W-1:0] PRE_LAST   = LEN_W'(PRE_BITS - 1);
  localparam logic [LEN_W-1:0] SYNC_LAST  = LEN_W'(SYNC_W - 1);
  localparam logic [LEN_W-1:0] GAP_LAST   = LEN_W'(GAP_BITS - 1);

  seq_state_e        state_q, state_d;
  logic [LEN_W-1:0]  bit_idx_q, bit_idx_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              stop_pend_q, stop_pend_d;
  logic              noise_lat_q, noise_lat_d;
  logic              tx_bit_q, tx_bit_d;
  logic              tx_valid_q, tx_valid_d;
  logic              noise_en_q, noise_en_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;

  logic              busy;
  logic              en0;
  logic              en1;
  logic              rate_load;
  logic              start_ok;
  logic              abort;
  logic              last_bit;
  logic [SYNC_W-1:0] sync_sh;

  assign busy     = (state_q != ST_IDLE);
  assign start_ok = (state_q == ST_IDLE) && bus.start && !bus.stop;
  // A stop arriving on the boundary cycle itself is honoured on that boundary.
  assign abort    = stop_pend_q || bus.stop;

  bit_rate_gen #(
    .DIV_W   (DIV_W),
    .DIV_MIN (DIV_MIN)
  ) u_rate (
    .clk     (clk),
    .rst_n   (rst_n),
    .run     (busy),
    .load    (rate_load),
    .cfg_div (bus.cfg_div),
    .en0     (en0),
    .en1     (en1)
  );

  always_comb begin
    last_bit = 1'b0;
    case (state_q)
      ST_PRE:  last_bit = (bit_idx_q == PRE_LAST);
      ST_SYNC: last_bit = (bit_idx_q == SYNC_LAST);
      ST_PAY:  last_bit = (bit_idx_q == (len_q - ONE_L));  // len_q >= 1 in PAY
      ST_GAP:  last_bit = (bit_idx_q == GAP_LAST);
      default: last_bit = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    bit_idx_d   = bit_idx_q;
    len_d       = len_q;
    stop_pend_d = stop_pend_q;
    noise_lat_d = noise_lat_q;
    tx_bit_d    = tx_bit_q;
    tx_valid_d  = tx_valid_q;
    noise_en_d  = noise_en_q;
    frame_cnt_d = frame_cnt_q;
    rate_load   = 1'b0;
    sync_sh     = '0;

    if (state_q == ST_IDLE) begin
      if (start_ok) begin
        state_d     = ST_PRE;
        bit_idx_d   = '0;
        len_d       = bus.cfg_len;
        noise_lat_d = bus.cfg_noise;
        stop_pend_d = 1'b0;
        rate_load   = 1'b1;
        tx_bit_d    = 1'b1;
        tx_valid_d  = 1'b1;
        noise_en_d  = bus.cfg_noise;
      end
    end else begin
      if (bus.stop) begin
        stop_pend_d = 1'b1;
      end
      // The LFSR advances on the same edge that closes a payload bit, so the
      // payload bit is re-registered every cycle; it settles to the new bit
      // one cycle into the bit period, well before the mid-bit strobe.
      if (state_q == ST_PAY) begin
        tx_bit_d = bus.lfsr_bit;
      end

      if (en0) begin
        if (last_bit) begin
          bit_idx_d = '0;
          case (state_q)
            ST_PRE:  state_d = ST_SYNC;
            ST_SYNC: state_d = (len_q == '0) ? ST_GAP : ST_PAY;
            ST_PAY:  state_d = ST_GAP;
            ST_GAP: begin
              frame_cnt_d = frame_cnt_q + 16'd1;
              if (bus.cfg_loop && !abort) begin
                state_d   = ST_PRE;
                len_d     = bus.cfg_len;
                rate_load = 1'b1;
              end else begin
                state_d = ST_IDLE;
              end
            end
            default: state_d = ST_IDLE;
          endcase
        end else begin
          bit_idx_d = bit_idx_q + ONE_L;
        end

        if (abort) begin
          state_d = ST_IDLE;
        end
        if (state_d == ST_IDLE) begin
          bit_idx_d   = '0;
          stop_pend_d = 1'b0;
        end

        // Outputs for the bit that starts on the next cycle.
        sync_sh    = SYNC_WORD << bit_idx_d;
        tx_valid_d = has_data(state_d);
        noise_en_d = has_data(state_d) && noise_lat_q;
        case (state_d)
          ST_PRE:  tx_bit_d = ~bit_idx_d[0];
          ST_SYNC: tx_bit_d = sync_sh[SYNC_W-1];
          ST_PAY:  tx_bit_d = bus.lfsr_bit;
          default: tx_bit_d = 1'b0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      bit_idx_q   <= '0;
      len_q       <= '0;
      stop_pend_q <= 1'b0;
      noise_lat_q <= 1'b0;
      tx_bit_q    <= 1'b0;
      tx_valid_q  <= 1'b0;
      noise_en_q  <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      bit_idx_q   <= bit_idx_d;
      len_q       <= len_d;
      stop_pend_q <= stop_pend_d;
      noise_lat_q <= noise_lat_d;
      tx_bit_q    <= tx_bit_d;
      tx_valid_q  <= tx_valid_d;
      noise_en_q  <= noise_en_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign bus.en0        = en0;
  assign bus.en1        = en1;
  assign bus.lfsr_clken = en0 && (state_q == ST_PAY);
  assign bus.tx_bit     = tx_bit_q;
  assign bus.tx_valid   = tx_valid_q;
  assign bus.noise_en   = noise_en_q;
  assign bus.busy       = busy;
  assign bus.frame_done = en0 && (state_q == ST_GAP) && last_bit;
  assign bus.frame_cnt  = frame_cnt_q;

endmodule
`default_nettype wire
